// File: rtl/mem_arbiter_pkg.sv
// Shared memory-subsystem constants for the I/D line arbiter: default widths,
// timeout default, timeout counter width and FSM state encoding.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF  = 64;
  localparam int unsigned LINE_W_DEF  = 256;
  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned CNT_W       = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Winner selection between instruction and data requesters.
// last_grant_d held low yields fixed data-first priority.
module arb_pick (
  input  logic i_valid,
  input  logic d_valid,
  input  logic last_grant_d,
  output logic grant_d_c
);

  // On contention hand the grant to whichever side did not win last time.
  assign grant_d_c = d_valid & (~i_valid | ~last_grant_d);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) line arbiter in front of a single RAM port.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; default is data-first.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned LINE_W  = LINE_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_valid_i,
  input  logic              i_req_rw_i,
  input  logic [ADDR_W-1:0] i_req_addr_i,
  input  logic [LINE_W-1:0] i_req_wdata_i,
  input  logic              d_req_valid_i,
  input  logic              d_req_rw_i,
  input  logic [ADDR_W-1:0] d_req_addr_i,
  input  logic [LINE_W-1:0] d_req_wdata_i,
  output logic              i_res_ready_o,
  output logic              d_res_ready_o,
  output logic [LINE_W-1:0] res_rdata_o,
  output logic              i_res_error_o,
  output logic              d_res_error_o,
  output logic              mem_valid_o,
  output logic              mem_rw_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  input  logic              dmem_error_i
);

  logic [1:0]       state_q, state_nxt;
  logic             own_d_q, own_d_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             mem_rw_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [LINE_W-1:0] mem_wdata_nxt;
  logic [LINE_W-1:0] rdata_nxt;
  logic             i_err_nxt, d_err_nxt;
  logic             i_ready_nxt, d_ready_nxt;
  logic             grant_d_c;
  logic             last_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_nxt;

  // Remembers which side won the most recent grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) last_d <= 1'b0;
    else       last_d <= last_d_nxt;
  end
`else
  assign last_d = 1'b0;
`endif

  arb_pick u_arb_pick (
    .i_valid      (i_req_valid_i),
    .d_valid      (d_req_valid_i),
    .last_grant_d (last_d),
    .grant_d_c    (grant_d_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state_q;
    own_d_nxt     = own_d_q;
    cnt_nxt       = cnt_q;
    mem_rw_nxt    = mem_rw_o;
    mem_addr_nxt  = mem_addr_o;
    mem_wdata_nxt = mem_wdata_o;
    rdata_nxt     = res_rdata_o;
    i_err_nxt     = i_res_error_o;
    d_err_nxt     = d_res_error_o;
    i_ready_nxt   = 1'b0;
    d_ready_nxt   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_nxt    = last_d;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_req_valid_i || d_req_valid_i) begin
          state_nxt = ST_BUSY;
          own_d_nxt = grant_d_c;
          cnt_nxt   = '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_nxt = grant_d_c;
`endif
          if (grant_d_c) begin
            mem_rw_nxt    = d_req_rw_i;
            mem_addr_nxt  = d_req_addr_i;
            mem_wdata_nxt = d_req_wdata_i;
          end else begin
            mem_rw_nxt    = i_req_rw_i;
            mem_addr_nxt  = i_req_addr_i;
            mem_wdata_nxt = i_req_wdata_i;
          end
        end
      end
      ST_BUSY: begin
        if (mem_ready_i) begin
          state_nxt = ST_RESP;
          rdata_nxt = mem_rdata_i;
          if (own_d_q) d_err_nxt = dmem_error_i;
          else         i_err_nxt = dmem_error_i;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
          // Count compared before increment, so TIMEOUT BUSY cycles elapse in total.
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_nxt = ST_RESP;
            rdata_nxt = '0;
            if (own_d_q) d_err_nxt = 1'b1;
            else         i_err_nxt = 1'b1;
          end
        end
      end
      ST_RESP: begin
        state_nxt   = ST_IDLE;
        i_ready_nxt = ~own_d_q;
        d_ready_nxt = own_d_q;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      own_d_q       <= 1'b0;
      cnt_q         <= '0;
      mem_valid_o   <= 1'b0;
      mem_rw_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      res_rdata_o   <= '0;
      i_res_error_o <= 1'b0;
      d_res_error_o <= 1'b0;
      i_res_ready_o <= 1'b0;
      d_res_ready_o <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      own_d_q       <= own_d_nxt;
      cnt_q         <= cnt_nxt;
      mem_valid_o   <= (state_nxt == ST_BUSY);
      mem_rw_o      <= mem_rw_nxt;
      mem_addr_o    <= mem_addr_nxt;
      mem_wdata_o   <= mem_wdata_nxt;
      res_rdata_o   <= rdata_nxt;
      i_res_error_o <= i_err_nxt;
      d_res_error_o <= d_err_nxt;
      i_res_ready_o <= i_ready_nxt;
      d_res_ready_o <= d_ready_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected RAM requests
// and responses into queues; a negedge monitor pops and compares them.
module tb_mem_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned LW = 256;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          i_req_valid_i = 1'b0, i_req_rw_i = 1'b0;
  logic [AW-1:0] i_req_addr_i = '0;
  logic [LW-1:0] i_req_wdata_i = '0;
  logic          d_req_valid_i = 1'b0, d_req_rw_i = 1'b0;
  logic [AW-1:0] d_req_addr_i = '0;
  logic [LW-1:0] d_req_wdata_i = '0;
  logic          i_res_ready_o, d_res_ready_o, i_res_error_o, d_res_error_o;
  logic [LW-1:0] res_rdata_o;
  logic          mem_valid_o, mem_rw_o;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_wdata_o;
  logic [LW-1:0] mem_rdata_i = '0;
  logic          mem_ready_i = 1'b0, dmem_error_i = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .i_req_valid_i(i_req_valid_i), .i_req_rw_i(i_req_rw_i),
    .i_req_addr_i(i_req_addr_i), .i_req_wdata_i(i_req_wdata_i),
    .d_req_valid_i(d_req_valid_i), .d_req_rw_i(d_req_rw_i),
    .d_req_addr_i(d_req_addr_i), .d_req_wdata_i(d_req_wdata_i),
    .i_res_ready_o(i_res_ready_o), .d_res_ready_o(d_res_ready_o),
    .res_rdata_o(res_rdata_o),
    .i_res_error_o(i_res_error_o), .d_res_error_o(d_res_error_o),
    .mem_valid_o(mem_valid_o), .mem_rw_o(mem_rw_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .dmem_error_i(dmem_error_i)
  );

  typedef struct { logic [AW-1:0] addr; logic rw; logic [LW-1:0] wdata; } mem_exp_t;
  typedef struct { logic side_d; logic err; logic [LW-1:0] rdata; } resp_exp_t;

  mem_exp_t  mem_q[$];
  resp_exp_t resp_q[$];
  int        total = 0;
  int        bad = 0;
  mem_exp_t  cur;
  resp_exp_t r;
  logic      mem_active = 1'b0;

  function automatic logic [LW-1:0] fill(input logic [7:0] b);
    return {32{b}};
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_txn(input logic [AW-1:0] addr, input logic rw, input logic [LW-1:0] wd,
                            input logic side_d, input logic err, input logic [LW-1:0] rd,
                            input bit with_resp);
    mem_exp_t  m;
    resp_exp_t e;
    m.addr = addr; m.rw = rw; m.wdata = wd;
    mem_q.push_back(m);
    if (with_resp) begin
      e.side_d = side_d; e.err = err; e.rdata = rd;
      resp_q.push_back(e);
    end
  endtask

  // Monitor: response pulses and RAM-side request contents.
  always @(negedge clk) begin
    if (i_res_ready_o || d_res_ready_o) begin
      if (resp_q.size() == 0) begin
        check("unexpected_ready", LW'({i_res_ready_o, d_res_ready_o}), LW'(0));
      end else begin
        r = resp_q.pop_front();
        check("ready_side", LW'({i_res_ready_o, d_res_ready_o}), LW'({~r.side_d, r.side_d}));
        check("res_error", LW'(r.side_d ? d_res_error_o : i_res_error_o), LW'(r.err));
        check("res_rdata", res_rdata_o, r.rdata);
      end
    end
    if (mem_valid_o) begin
      if (!mem_active) begin
        mem_active = 1'b1;
        if (mem_q.size() == 0) begin
          check("unexpected_mem_valid", LW'(mem_valid_o), LW'(0));
          cur.addr = mem_addr_o; cur.rw = mem_rw_o; cur.wdata = mem_wdata_o;
        end else begin
          cur = mem_q.pop_front();
        end
      end
      check("mem_addr", LW'(mem_addr_o), LW'(cur.addr));
      check("mem_rw", LW'(mem_rw_o), LW'(cur.rw));
      check("mem_wdata", mem_wdata_o, cur.wdata);
    end else begin
      mem_active = 1'b0;
    end
  end

  task automatic wait_grant();
    int n = 0;
    @(negedge clk);
    while (!mem_valid_o && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("grant_wait", LW'(mem_valid_o), LW'(1));
  endtask

  task automatic ram_respond(input int delay, input logic [LW-1:0] rd, input logic err);
    repeat (delay - 1) begin
      @(posedge clk); #1;
    end
    mem_ready_i = 1'b1; mem_rdata_i = rd; dmem_error_i = err;
    @(posedge clk); #1;
    mem_ready_i = 1'b0; mem_rdata_i = '0; dmem_error_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((resp_q.size() != 0 || mem_q.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, LW'(resp_q.size() + mem_q.size()), LW'(0));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_valid", LW'(mem_valid_o), LW'(0));
    check("rst_ready", LW'({i_res_ready_o, d_res_ready_o}), LW'(0));
    check("rst_err", LW'({i_res_error_o, d_res_error_o}), LW'(0));
    check("rst_mem_rw", LW'(mem_rw_o), LW'(0));
    check("rst_mem_addr", LW'(mem_addr_o), LW'(0));
    check("rst_mem_wdata", mem_wdata_o, LW'(0));
    check("rst_rdata", res_rdata_o, LW'(0));
    @(posedge clk); #1 rst_i = 1'b0;

    // Single d read to 0x40, RAM ready on second BUSY cycle
    expect_txn(64'h40, 1'b0, LW'(0), 1'b1, 1'b0, fill(8'hAA), 1'b1);
    d_req_valid_i = 1'b1; d_req_rw_i = 1'b0; d_req_addr_i = 64'h40; d_req_wdata_i = '0;
    wait_grant();
    d_req_valid_i = 1'b0;
    ram_respond(2, fill(8'hAA), 1'b0);
    drain("drain_single_read");

    // Contention from a clean last-grant state
    do_reset();
    i_req_valid_i = 1'b1; i_req_rw_i = 1'b0; i_req_addr_i = 64'h200; i_req_wdata_i = fill(8'h12);
    d_req_valid_i = 1'b1; d_req_rw_i = 1'b1; d_req_addr_i = 64'h100; d_req_wdata_i = fill(8'h34);
`ifdef ARB_ROUND_ROBIN_EN
    expect_txn(64'h100, 1'b1, fill(8'h34), 1'b1, 1'b0, fill(8'h01), 1'b1);
    expect_txn(64'h200, 1'b0, fill(8'h12), 1'b0, 1'b0, fill(8'h02), 1'b1);
    wait_grant();
    ram_respond(1, fill(8'h01), 1'b0);
    wait_grant();
    i_req_valid_i = 1'b0; d_req_valid_i = 1'b0;
    ram_respond(1, fill(8'h02), 1'b0);
`else
    expect_txn(64'h100, 1'b1, fill(8'h34), 1'b1, 1'b0, fill(8'h01), 1'b1);
    expect_txn(64'h100, 1'b1, fill(8'h34), 1'b1, 1'b0, fill(8'h02), 1'b1);
    expect_txn(64'h200, 1'b0, fill(8'h12), 1'b0, 1'b0, fill(8'h03), 1'b1);
    wait_grant();
    ram_respond(1, fill(8'h01), 1'b0);
    wait_grant();
    d_req_valid_i = 1'b0;
    ram_respond(1, fill(8'h02), 1'b0);
    wait_grant();
    i_req_valid_i = 1'b0;
    ram_respond(1, fill(8'h03), 1'b0);
`endif
    drain("drain_contention");

    // d write to 0x80, RAM never answers; inputs wiggle during BUSY
    expect_txn(64'h80, 1'b1, fill(8'h5A), 1'b1, 1'b1, LW'(0), 1'b1);
    d_req_valid_i = 1'b1; d_req_rw_i = 1'b1; d_req_addr_i = 64'h80; d_req_wdata_i = fill(8'h5A);
    @(posedge clk); #1;
    d_req_valid_i = 1'b0; d_req_rw_i = 1'b0; d_req_addr_i = 64'hDEAD; d_req_wdata_i = fill(8'hEE);
    cyc = 0;
    while (!d_res_ready_o && cyc < 12) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("timeout_latency", LW'(cyc), LW'(5));
    @(posedge clk); @(negedge clk);
    check("timeout_back_idle", LW'({mem_valid_o, d_res_ready_o}), LW'(0));
    drain("drain_timeout");

    // i read to 0xFFFF_FFF0 with RAM error
    expect_txn(64'hFFFF_FFF0, 1'b0, fill(8'h66), 1'b0, 1'b1, fill(8'h55), 1'b1);
    i_req_valid_i = 1'b1; i_req_rw_i = 1'b0; i_req_addr_i = 64'hFFFF_FFF0; i_req_wdata_i = fill(8'h66);
    wait_grant();
    i_req_valid_i = 1'b0;
    ram_respond(1, fill(8'h55), 1'b1);
    drain("drain_i_error");
    check("d_err_hold", LW'(d_res_error_o), LW'(1));

    // mem_ready_i in IDLE must be ignored
    mem_ready_i = 1'b1; mem_rdata_i = fill(8'h77); dmem_error_i = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    mem_ready_i = 1'b0; mem_rdata_i = '0;
    @(negedge clk);
    check("idle_ready_rdata", res_rdata_o, fill(8'h55));
    check("idle_ready_ierr", LW'(i_res_error_o), LW'(1));
    check("idle_ready_valid", LW'(mem_valid_o), LW'(0));

    // Reset on second BUSY cycle abandons the transaction
    @(posedge clk); #1;
    expect_txn(64'h500, 1'b0, LW'(0), 1'b1, 1'b0, LW'(0), 1'b0);
    d_req_valid_i = 1'b1; d_req_rw_i = 1'b0; d_req_addr_i = 64'h500; d_req_wdata_i = '0;
    wait_grant();
    d_req_valid_i = 1'b0;
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_mem_valid", LW'(mem_valid_o), LW'(0));
    check("abort_mem_addr", LW'(mem_addr_o), LW'(0));
    check("abort_err", LW'({i_res_error_o, d_res_error_o}), LW'(0));
    @(posedge clk); #1 rst_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_queue", LW'(mem_q.size()), LW'(0));

    // Fresh request after the abort completes normally
    expect_txn(64'h300, 1'b0, fill(8'h9C), 1'b0, 1'b0, fill(8'hC3), 1'b1);
    i_req_valid_i = 1'b1; i_req_rw_i = 1'b0; i_req_addr_i = 64'h300; i_req_wdata_i = fill(8'h9C);
    wait_grant();
    i_req_valid_i = 1'b0;
    ram_respond(3, fill(8'hC3), 1'b0);
    drain("drain_after_abort");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 64, address width of every request and memory port.
REQ-002 Parameter LINE_W, 256, cache-line data width.
REQ-003 Parameter TIMEOUT, 255, maximum BUSY cycles before a forced error response; legal range 2..255.
REQ-004 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset, synchronous and active-high.
REQ-006 i_req_valid_i / i_req_rw_i / i_req_addr_i / i_req_wdata_i  in  1/1/ADDR_W/LINE_W  instruction-cache line request.
REQ-007 d_req_valid_i / d_req_rw_i / d_req_addr_i / d_req_wdata_i  in  1/1/ADDR_W/LINE_W  data-cache line request.
REQ-008 i_res_ready_o / d_res_ready_o  out  1  one-cycle completion pulse to the granted requester.
REQ-009 res_rdata_o  out  LINE_W  registered read line; valid while either ready pulse is high.
REQ-010 i_res_error_o / d_res_error_o  out  1  error flag, qualified by the matching ready pulse.
REQ-011 mem_valid_o / mem_rw_o / mem_addr_o / mem_wdata_o  out  1/1/ADDR_W/LINE_W  registered request to the RAM.
REQ-012 mem_rdata_i / mem_ready_i / dmem_error_i  in  LINE_W/1/1  RAM response.

Function
REQ-013 FSM states IDLE, BUSY, RESP; reset state IDLE.
REQ-014 IDLE: no valid request -> stay IDLE; one or more valid requests -> pick winner per REQ-021/022, latch its rw/addr/wdata into the mem_* registers, record the grant owner, clear the timeout counter, go to BUSY.
REQ-015 mem_valid_o is high exactly while in BUSY; request at edge N gives mem_valid_o high from cycle N+1.
REQ-016 mem_rw_o, mem_addr_o and mem_wdata_o hold constant throughout BUSY regardless of requester inputs.
REQ-017 BUSY with mem_ready_i high: capture mem_rdata_i into res_rdata_o and dmem_error_i into the owner's error flag, go to RESP.
REQ-018 BUSY without mem_ready_i: increment the 8-bit timeout counter; when it equals TIMEOUT-1, go to RESP with the owner's error flag set and res_rdata_o forced to zero.
REQ-019 RESP: assert only the owner's *_res_ready_o for exactly one cycle, then go to IDLE; no new grant is issued in RESP.
REQ-020 Minimum turnaround request-to-ready is 3 cycles when mem_ready_i arrives on the first BUSY cycle.
REQ-021 Without ARB_ROUND_ROBIN_EN: simultaneous requests grant the data side.
REQ-022 With ARB_ROUND_ROBIN_EN: simultaneous requests grant the side not granted last; the last-grant bit resets to instruction, so the first contention grants data.
REQ-023 A requester dropping valid during BUSY does not abort the transaction; its ready pulse is still issued.
REQ-024 mem_ready_i outside BUSY is ignored.
REQ-025 Error flags and res_rdata_o hold their value until the next capture; only the ready pulses are single-cycle.

Reset
REQ-026 With rst_i high at an edge: state IDLE, mem_valid_o 0, both ready pulses 0, both error flags 0, mem_rw_o 0, mem_addr_o 0, mem_wdata_o 0, res_rdata_o 0, timeout counter 0, last-grant instruction.
REQ-027 Reset during BUSY or RESP abandons the transaction; no ready pulse is emitted for it.

Configuration
REQ-028 Macro ARB_ROUND_ROBIN_EN: defined -> round-robin contention with a last-grant register; undefined -> fixed data-first priority with no last-grant register.

Structure
REQ-029 The state encoding, ADDR_W/LINE_W defaults and TIMEOUT default live in the shared define file with the other memory constants.
REQ-030 The winner selection is one combinational sub-module, arb_pick (inputs: two valids and the last-grant bit; output: grant-data bit).

Verification
REQ-031 A single d read to addr 0x40, RAM ready after 2 cycles with line 0xAA..AA -> mem_addr_o 0x40 and mem_rw_o 0, one d_res_ready_o pulse, res_rdata_o 0xAA..AA, no i pulse.
REQ-032 i and d requesting together, macro undefined, then both again -> both transactions go to d; i completes only after d drops valid.
REQ-033 i and d requesting together twice, macro defined -> grants d then i; each ready pulse fires once.
REQ-034 A d write to 0x80 and the RAM never ready, TIMEOUT=4 -> d_res_error_o set with d_res_ready_o at cycle 5 after the request, res_rdata_o 0, return to IDLE.
REQ-035 dmem_error_i high with mem_ready_i on an i read to 0xFFFF_FFF0 -> i_res_error_o 1 with the i ready pulse.
REQ-036 rst_i asserted on the second BUSY cycle -> mem_valid_o 0 the next cycle, no ready pulse, and a fresh request afterwards completes normally.
